// File: rtl/fifo_pkg.sv
// Shared sizing helpers and read-mode encoding for the flexible FIFO.
package fifo_pkg;

    typedef enum logic {
        FIFO_STD  = 1'b0,
        FIFO_FWFT = 1'b1
    } fifo_mode_e;

    function automatic int fifo_depth(input int addr_width);
        return 1 << addr_width;
    endfunction

    // One extra bit so the count can represent a completely full FIFO.
    function automatic int fifo_cnt_w(input int addr_width);
        return addr_width + 1;
    endfunction

endpackage

// File: rtl/fifo_mem.sv
// Register-array storage: one synchronous write port, one asynchronous read port.
module fifo_mem
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 24,
    parameter int ADDR_WIDTH = 3
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] w_addr,
    input  logic [DATA_WIDTH-1:0] w_data,
    input  logic [ADDR_WIDTH-1:0] r_addr,
    output logic [DATA_WIDTH-1:0] r_data
);

    localparam int DEPTH = fifo_depth(ADDR_WIDTH);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    // NOTE: storage has no reset; stale contents are never visible because
    // the pointers and count are reset, and a reset array would cost a mux per bit.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[w_addr] <= w_data;
        end
    end

    assign r_data = mem_q[r_addr];

endmodule

// File: rtl/fifo_flex.sv
// Parametrised synchronous FIFO with occupancy flags, FWFT option, flush
// and sticky overflow/underflow reporting.
module fifo_flex
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 24,
    parameter int ADDR_WIDTH = 3,
    parameter int FWFT       = 0,
    parameter int AF_LEVEL   = (1 << ADDR_WIDTH) - 2,
    parameter int AE_LEVEL   = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  flush,
    input  logic                  rd,
    input  logic                  wr,
    input  logic [DATA_WIDTH-1:0] w_data,
    input  logic                  clr_err,
    output logic [DATA_WIDTH-1:0] r_data,
    output logic                  r_valid,
    output logic                  empty,
    output logic                  full,
    output logic                  almost_empty,
    output logic                  almost_full,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int                DEPTH   = fifo_depth(ADDR_WIDTH);
    localparam int                CW      = fifo_cnt_w(ADDR_WIDTH);
    localparam logic [CW-1:0]     DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0]     AF_C    = CW'(AF_LEVEL);
    localparam logic [CW-1:0]     AE_C    = CW'(AE_LEVEL);
    localparam logic [CW-1:0]     CNT_ONE = CW'(1);
    localparam logic [ADDR_WIDTH-1:0] PTR_ONE = ADDR_WIDTH'(1);
    localparam fifo_mode_e        MODE    = (FWFT != 0) ? FIFO_FWFT : FIFO_STD;

    if (AF_LEVEL < 1 || AF_LEVEL > DEPTH) begin : g_bad_af
        $error("fifo_flex: AF_LEVEL %0d outside 1..%0d", AF_LEVEL, DEPTH);
    end
    if (AE_LEVEL < 0 || AE_LEVEL > DEPTH - 1) begin : g_bad_ae
        $error("fifo_flex: AE_LEVEL %0d outside 0..%0d", AE_LEVEL, DEPTH - 1);
    end

    logic [ADDR_WIDTH-1:0] w_ptr_q, w_ptr_d;
    logic [ADDR_WIDTH-1:0] r_ptr_q, r_ptr_d;
    logic [CW-1:0]         count_q, count_d;
    logic [DATA_WIDTH-1:0] r_data_q, r_data_d;
    logic                  r_valid_q, r_valid_d;
    logic                  overflow_q, overflow_d;
    logic                  underflow_q, underflow_d;
    logic [DATA_WIDTH-1:0] mem_rdata;
    logic                  rd_ok, wr_ok, mem_we;

    // Status flags decode the count register only, never the live rd/wr.
    assign empty        = (count_q == '0);
    assign full         = (count_q == DEPTH_C);
    assign almost_empty = (count_q <= AE_C);
    assign almost_full  = (count_q >= AF_C);
    assign count        = count_q;
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;

    // A full FIFO still accepts a write when the same edge pops a word.
    assign rd_ok  = rd & ~empty;
    assign wr_ok  = wr & (~full | rd_ok);
    assign mem_we = wr_ok & ~flush;

    fifo_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_mem (
        .clk    (clk),
        .we     (mem_we),
        .w_addr (w_ptr_q),
        .w_data (w_data),
        .r_addr (r_ptr_q),
        .r_data (mem_rdata)
    );

    always_comb begin
        // NOTE: every next-state value is defaulted first so no path leaves
        // a variable unassigned and infers a latch.
        w_ptr_d     = w_ptr_q;
        r_ptr_d     = r_ptr_q;
        count_d     = count_q;
        r_data_d    = r_data_q;
        r_valid_d   = 1'b0;
        overflow_d  = overflow_q  & ~clr_err;
        underflow_d = underflow_q & ~clr_err;

        if (flush) begin
            w_ptr_d = '0;
            r_ptr_d = '0;
            count_d = '0;
        end else begin
            if (wr_ok) w_ptr_d = w_ptr_q + PTR_ONE;
            if (rd_ok) begin
                r_ptr_d   = r_ptr_q + PTR_ONE;
                r_data_d  = mem_rdata;
                r_valid_d = 1'b1;
            end
            case ({wr_ok, rd_ok})
                2'b10:   count_d = count_q + CNT_ONE;
                2'b01:   count_d = count_q - CNT_ONE;
                default: count_d = count_q;
            endcase
            // Setting after the clear makes a coincident set win over clr_err.
            if (wr & ~wr_ok) overflow_d  = 1'b1;
            if (rd & ~rd_ok) underflow_d = 1'b1;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            w_ptr_q     <= '0;
            r_ptr_q     <= '0;
            count_q     <= '0;
            r_data_q    <= '0;
            r_valid_q   <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            w_ptr_q     <= w_ptr_d;
            r_ptr_q     <= r_ptr_d;
            count_q     <= count_d;
            r_data_q    <= r_data_d;
            r_valid_q   <= r_valid_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    if (MODE == FIFO_FWFT) begin : g_fwft
        assign r_data  = empty ? '0 : mem_rdata;
        assign r_valid = ~empty;
    end else begin : g_std
        assign r_data  = r_data_q;
        assign r_valid = r_valid_q;
    end

endmodule

// File: tb/tb_fifo_flex.sv
// Directed bench for fifo_flex: a standard-read and an FWFT instance share stimulus.
module tb_fifo_flex;

    logic        clk;
    logic        reset;
    logic        flush;
    logic        rd;
    logic        wr;
    logic [23:0] w_data;
    logic        clr_err;

    logic [23:0] s_r_data, f_r_data;
    logic        s_r_valid, f_r_valid;
    logic        s_empty, f_empty, s_full, f_full;
    logic        s_ae, f_ae, s_af, f_af;
    logic [3:0]  s_count, f_count;
    logic        s_ovf, f_ovf, s_unf, f_unf;

    int checks = 0;
    int errors = 0;

    fifo_flex #(.DATA_WIDTH(24), .ADDR_WIDTH(3), .FWFT(0), .AF_LEVEL(6), .AE_LEVEL(2)) u_std (
        .clk(clk), .reset(reset), .flush(flush), .rd(rd), .wr(wr), .w_data(w_data),
        .clr_err(clr_err), .r_data(s_r_data), .r_valid(s_r_valid), .empty(s_empty),
        .full(s_full), .almost_empty(s_ae), .almost_full(s_af), .count(s_count),
        .overflow(s_ovf), .underflow(s_unf)
    );

    fifo_flex #(.DATA_WIDTH(24), .ADDR_WIDTH(3), .FWFT(1), .AF_LEVEL(6), .AE_LEVEL(2)) u_fwft (
        .clk(clk), .reset(reset), .flush(flush), .rd(rd), .wr(wr), .w_data(w_data),
        .clr_err(clr_err), .r_data(f_r_data), .r_valid(f_r_valid), .empty(f_empty),
        .full(f_full), .almost_empty(f_ae), .almost_full(f_af), .count(f_count),
        .overflow(f_ovf), .underflow(f_unf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, " count"},   32'(s_count),   0);
        check({tag, " empty"},   32'(s_empty),   1);
        check({tag, " full"},    32'(s_full),    0);
        check({tag, " ae"},      32'(s_ae),      1);
        check({tag, " af"},      32'(s_af),      0);
        check({tag, " r_data"},  32'(s_r_data),  0);
        check({tag, " r_valid"}, 32'(s_r_valid), 0);
        check({tag, " ovf"},     32'(s_ovf),     0);
        check({tag, " unf"},     32'(s_unf),     0);
        check({tag, " f_rdata"}, 32'(f_r_data),  0);
        check({tag, " f_valid"}, 32'(f_r_valid), 0);
        check({tag, " f_count"}, 32'(f_count),   0);
    endtask

    initial begin
        logic [23:0] drain_exp [8];
        drain_exp = '{24'd4, 24'd5, 24'd6, 24'd7, 24'd8, 24'd100, 24'd100, 24'd100};

        reset = 1'b0; flush = 1'b0; rd = 1'b0; wr = 1'b0; w_data = '0; clr_err = 1'b0;
        #1;
        check_reset_state("reset");
        #1 reset = 1'b1;

        // 1: fill to full, then one rejected write
        for (int i = 1; i <= 8; i++) begin
            wr = 1'b1; w_data = 24'(i);
            tick();
            check("fill count", 32'(s_count), 32'(i));
            check("fill af",    32'(s_af),    32'(i >= 6));
            check("fill ae",    32'(s_ae),    32'(i <= 2));
        end
        check("fill full", 32'(s_full), 1);
        w_data = 24'd9;
        tick();
        wr = 1'b0;
        check("ovf set",     32'(s_ovf),   1);
        check("ovf count",   32'(s_count), 8);
        check("ovf no unf",  32'(s_unf),   0);

        // 2: simultaneous read/write while full
        for (int k = 1; k <= 3; k++) begin
            rd = 1'b1; wr = 1'b1; w_data = 24'd100;
            tick();
            check("rw r_data",  32'(s_r_data),  32'(k));
            check("rw r_valid", 32'(s_r_valid), 1);
            check("rw count",   32'(s_count),   8);
            check("rw full",    32'(s_full),    1);
            check("rw ovf",     32'(s_ovf),     1);
        end
        wr = 1'b0;

        // 3: drain, underflow, clear errors
        for (int k = 0; k < 8; k++) begin
            rd = 1'b1;
            tick();
            check("drain r_data",  32'(s_r_data),  32'(drain_exp[k]));
            check("drain r_valid", 32'(s_r_valid), 1);
        end
        check("drain empty", 32'(s_empty), 1);
        check("drain count", 32'(s_count), 0);
        tick();
        rd = 1'b0;
        check("unf set",     32'(s_unf),     1);
        check("unf r_data",  32'(s_r_data),  100);
        check("unf r_valid", 32'(s_r_valid), 0);
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        check("clr ovf", 32'(s_ovf), 0);
        check("clr unf", 32'(s_unf), 0);

        // 4: interleaved single write/read across pointer wrap
        for (int i = 0; i < 20; i++) begin
            wr = 1'b1; rd = 1'b0; w_data = 24'(i);
            tick();
            check("wrap wcount",  32'(s_count),   1);
            check("wrap wvalid",  32'(s_r_valid), 0);
            check("wrap f_rdata", 32'(f_r_data),  32'(i));
            check("wrap f_valid", 32'(f_r_valid), 1);
            wr = 1'b0; rd = 1'b1;
            tick();
            check("wrap r_data",  32'(s_r_data),  32'(i));
            check("wrap r_valid", 32'(s_r_valid), 1);
            check("wrap rcount",  32'(s_count),   0);
        end
        rd = 1'b0;
        check("wrap ovf", 32'(s_ovf), 0);
        check("wrap unf", 32'(s_unf), 0);

        // 5: FWFT visibility without rd, then pop
        wr = 1'b1; w_data = 24'hABCDEF;
        tick();
        wr = 1'b0;
        check("fwft r_data",  32'(f_r_data),  32'h00ABCDEF);
        check("fwft r_valid", 32'(f_r_valid), 1);
        check("std no valid", 32'(s_r_valid), 0);
        rd = 1'b1;
        tick();
        rd = 1'b0;
        check("fwft empty",   32'(f_empty),   1);
        check("fwft r_data0", 32'(f_r_data),  0);
        check("fwft valid0",  32'(f_r_valid), 0);
        check("std pop data", 32'(s_r_data),  32'h00ABCDEF);

        // 6: flush with rd/wr, then asynchronous reset mid-burst
        for (int i = 0; i < 5; i++) begin
            wr = 1'b1; w_data = 24'(50 + i);
            tick();
        end
        check("pre-flush count", 32'(s_count), 5);
        flush = 1'b1; rd = 1'b1; wr = 1'b1; w_data = 24'd77;
        tick();
        flush = 1'b0; rd = 1'b0; wr = 1'b0;
        check("flush count",   32'(s_count),   0);
        check("flush empty",   32'(s_empty),   1);
        check("flush ovf",     32'(s_ovf),     0);
        check("flush unf",     32'(s_unf),     0);
        check("flush r_valid", 32'(s_r_valid), 0);
        check("flush r_data",  32'(s_r_data),  32'h00ABCDEF);
        check("flush f_count", 32'(f_count),   0);
        for (int i = 0; i < 4; i++) begin
            wr = 1'b1; w_data = 24'(60 + i);
            tick();
        end
        wr = 1'b0;
        check("burst count", 32'(s_count), 4);
        #2 reset = 1'b0;
        #1;
        check_reset_state("async reset");
        #2 reset = 1'b1;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fifo_flex.md
Name: fifo_flex

Overview:
Parametrised successor to the lab's basic synchronous FIFO, for buffering 24-bit audio samples between the codec interface and the processing datapath. Adds:
- occupancy count and programmable almost-full/almost-empty levels
- a first-word-fall-through (FWFT) read mode
- simultaneous read/write when full
- synchronous flush
- sticky overflow/underflow error flags

Storage is a 2**ADDR_WIDTH-entry register array. Pointers are ADDR_WIDTH bits and wrap naturally.

Parameters:
DATA_WIDTH, 24, bits per word
ADDR_WIDTH, 3, address bits; DEPTH = 2**ADDR_WIDTH
FWFT, 0, 0 = standard registered read; 1 = first-word-fall-through
AF_LEVEL, DEPTH-2, almost_full asserted when count >= AF_LEVEL (legal 1..DEPTH)
AE_LEVEL, 2, almost_empty asserted when count <= AE_LEVEL (legal 0..DEPTH-1)

Ports:
clk  in  1  system clock, all state on rising edge
reset  in  1  asynchronous, active-low reset (asserted at 0)
flush  in  1  synchronous clear of pointers and count
rd  in  1  read/pop request
wr  in  1  write/push request
w_data  in  DATA_WIDTH  write word
clr_err  in  1  synchronous clear of overflow/underflow
r_data  out  DATA_WIDTH  read word
r_valid  out  1  standard mode: r_data updated this cycle; FWFT: equals ~empty
empty  out  1  count == 0
full  out  1  count == DEPTH
almost_empty  out  1  count <= AE_LEVEL
almost_full  out  1  count >= AF_LEVEL
count  out  ADDR_WIDTH+1  current occupancy, 0..DEPTH
overflow  out  1  sticky: write rejected
underflow  out  1  sticky: read rejected

Behaviour:
- Reset (reset==0, asynchronous) forces these values:
  - w_ptr = r_ptr = 0, count = 0
  - empty = 1, full = 0, almost_empty = 1, almost_full = 0
  - r_data = 0, r_valid = 0, overflow = 0, underflow = 0
  - Memory contents are not reset. Reset mid-operation discards all queued data.
- Accept rules, evaluated on the registered state before the edge:
  - rd_ok = rd & ~empty
  - wr_ok = wr & (~full | rd_ok)
- Count update:
  - wr_ok only: count +1
  - rd_ok only: count -1
  - both: count unchanged, both pointers advance
- Full + rd + wr: both accepted; oldest word leaves; new word stored at w_ptr (== r_ptr before the edge). No overflow is flagged.
- Empty + rd + wr: write accepted, read rejected. underflow is set. Count becomes 1.
- Flags empty, full, almost_* are decoded from the count register only. They change in the cycle after the accepting edge and never depend combinationally on rd/wr.
- Pointers wrap DEPTH-1 -> 0.
- Standard mode (FWFT=0):
  - On an edge with rd_ok, r_data <= mem[r_ptr] and r_valid <= 1. Otherwise r_valid <= 0 and r_data holds.
  - Read latency is 1 cycle.
- FWFT mode (FWFT=1):
  - r_data = mem[r_ptr] combinationally whenever ~empty; it is 0 when empty.
  - r_valid = ~empty. rd pops the displayed word; the next word appears after the edge.
  - A word written into an empty FIFO is visible the cycle after the write.
- Sticky flags:
  - overflow <= 1 on wr & ~wr_ok.
  - underflow <= 1 on rd & ~rd_ok.
  - Both hold until clr_err or reset. If a set and clr_err occur in the same cycle, set wins.
- flush: pointers and count go to 0 on the edge. Priority is reset > flush > rd/wr; rd/wr are ignored in a flush cycle and set no error flags. Sticky flags and r_data are unaffected; r_valid <= 0.
- Parameter checks: elaboration $error if AF_LEVEL or AE_LEVEL is out of range.

Decomposition:
- Shared package fifo_pkg:
  - localparam function for DEPTH and count width
  - typedef fifo_mode_e {FIFO_STD, FIFO_FWFT} used to document the FWFT values
- Sub-module fifo_mem holds storage: write port (clk, we, w_addr, w_data) and asynchronous read port (r_addr -> r_data). No reset.
- fifo_flex contains the pointers, count, flags and read-data register.

Test Plan (DATA_WIDTH=24, ADDR_WIDTH=3, AF_LEVEL=6, AE_LEVEL=2, FWFT=0 unless noted):
1. Reset, then write 1..8 on consecutive cycles -> count=8, full=1, almost_full set after the 6th write. A 9th write of 9 -> not stored, overflow=1.
2. From full, rd=wr=1 with w_data 100 for 3 cycles -> count stays 8; r_data sequence 1,2,3 with r_valid=1; full stays 1; overflow unchanged.
3. Drain 8 reads -> r_data 4..8 then 100,100,100; empty=1 after the last read. A further rd -> underflow=1; r_data holds 100. clr_err -> both flags 0.
4. Pointer wrap: 20 cycles of interleaved single write/read with w_data = i -> r_data = i one cycle after each rd; count toggles 0/1; no flags set.
5. FWFT=1: write 0xABCDEF into empty -> next cycle r_data=0xABCDEF, r_valid=1 with no rd. rd -> empty=1, r_data=0.
6. Write 5 words, then flush together with rd=wr=1 -> count=0, empty=1, no errors. Separately, assert reset mid-burst with count=4 -> all outputs return to their reset values immediately, without waiting for a clock edge.
